// File: rtl/gauss_pkg.sv
// Shared constants for the Gaussian filter and its frame-capture sink.
// Line length and warm-up latency live here so both blocks stay consistent.
package gauss_pkg;

  localparam int DEF_IMG_W  = 400;
  localparam int DEF_IMG_H  = 300;
  localparam int DEF_LAT    = 2 * DEF_IMG_W + 2;
  localparam int DEF_ADDR_W = $clog2(DEF_IMG_W * DEF_IMG_H);
  localparam int DEF_FIFO_D = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SKIP    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } cap_state_e;

  // Counter width able to hold max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/gauss_frame_capture_fifo.sv
// Small synchronous FIFO; the head entry is read straight from the storage flops,
// so a pushed word is visible right after the edge that wrote it.
module capture_fifo
  import gauss_pkg::*;
#(
  parameter int DW    = 25,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == {CW{1'b0}});
  assign dout  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves in the same cycle;
  // then the freed head slot is exactly the write slot.
  assign push_ok_s = push & (~full | pop);
  assign pop_ok_s  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/gauss_frame_capture.sv
// Frame capture sink for the 5x5 Gaussian stage: drops warm-up samples, tags
// pixels with raster addresses and hands them to frame memory through a FIFO.
module gauss_frame_capture
  import gauss_pkg::*;
#(
  parameter int IMG_W  = gauss_pkg::DEF_IMG_W,
  parameter int IMG_H  = gauss_pkg::DEF_IMG_H,
  parameter int LAT    = gauss_pkg::DEF_LAT,
  parameter int FIFO_D = gauss_pkg::DEF_FIFO_D,
  parameter int ADDR_W = gauss_pkg::DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        pix_in,
  input  logic              pix_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
);

  localparam int                SKIP_W    = cnt_width(LAT);
  localparam int                DW        = ADDR_W + 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(LAT - 1);

  cap_state_e        state_q, state_d;
  logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              overflow_q, overflow_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;

  logic              push_s;
  logic              pop_s;
  logic              drop_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [DW-1:0]     fifo_dout_s;

  assign push_s = (state_q == ST_CAPTURE) & pix_en;
  assign pop_s  = ~fifo_empty_s & mem_ready;
  assign drop_s = push_s & fifo_full_s & ~pop_s;

  capture_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_D)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .din   ({wr_addr_q, pix_in}),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign mem_addr   = fifo_dout_s[DW-1:8];
  assign mem_data   = fifo_dout_s[7:0];
  assign mem_valid  = ~fifo_empty_s;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

  // Next-state, counters and sticky overflow for the capture sequence.
  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    wr_addr_d  = wr_addr_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          skip_cnt_d = {SKIP_W{1'b0}};
          wr_addr_d  = {ADDR_W{1'b0}};
          overflow_d = 1'b0;
          state_d    = (LAT > 0) ? ST_SKIP : ST_CAPTURE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SKIP: begin
        if (pix_en) begin
          skip_cnt_d = skip_cnt_q + SKIP_W'(1);
          if (skip_cnt_q == SKIP_LAST) begin
            state_d = ST_CAPTURE;
          end else begin
            state_d = ST_SKIP;
          end
        end else begin
          state_d = ST_SKIP;
        end
      end
      ST_CAPTURE: begin
        if (drop_s) begin
          overflow_d = 1'b1;
        end else begin
          overflow_d = overflow_q;
        end
        // The last address is held rather than incremented so it never wraps.
        if (pix_en) begin
          if (wr_addr_q == LAST_ADDR) begin
            state_d = ST_DRAIN;
          end else begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
          end
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_DONE);
  end

  // Capture FSM state, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      skip_cnt_q   <= {SKIP_W{1'b0}};
      wr_addr_q    <= {ADDR_W{1'b0}};
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      skip_cnt_q   <= skip_cnt_d;
      wr_addr_q    <= wr_addr_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
